// File: rtl/sat_add_arbiter_if.sv
// Requester/consumer bundle for sat_add_arbiter: NREQ operand ports in,
// one registered saturated-sum result port out.
interface sat_add_arbiter_if #(
  parameter int WIDTH = 6,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_sat;
  logic                  rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sat
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_sat
  );
endinterface

// File: rtl/sat_add_arbiter.sv
// Round-robin arbiter sharing one saturating adder with a 1-deep result register.
// Optional macro SAT_ADD_ARB_STATS_EN adds the 16-bit sat_count output.
module sat_add_arbiter #(
  parameter int WIDTH = 6,
  parameter int NREQ  = 4
) (
  input  logic clk,
  input  logic rst_n,
  sat_add_arbiter_if.slave bus
`ifdef SAT_ADD_ARB_STATS_EN
  ,
  output logic [15:0] sat_count
`endif
);
  localparam int          IDW = $clog2(NREQ);
  localparam int unsigned NR  = NREQ;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
  logic             rsp_sat_q, rsp_sat_d;

  logic             free;
  logic             found;
  logic             xfer;
  logic [IDW-1:0]   gnt_id;
  logic [WIDTH-1:0] op_a, op_b, sum_raw, sum_sat;
  logic             ovf;

  // Round-robin search starting at ptr_q, wrapping modulo NREQ.
  always_comb begin : arbitrate
    int unsigned idx;
    idx    = 0;
    found  = 1'b0;
    gnt_id = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = (32'(ptr_q) + k) % NR;
      if (!found && bus.req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = IDW'(idx);
      end
    end
  end

  always_comb begin : datapath
    op_a    = bus.req_a[gnt_id*WIDTH +: WIDTH];
    op_b    = bus.req_b[gnt_id*WIDTH +: WIDTH];
    sum_raw = op_a + op_b;
    ovf     = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_raw[WIDTH-1] != op_a[WIDTH-1]);
    // Clamp value shares the operand sign bit: 0111.. or 1000..
    sum_sat = ovf ? {op_a[WIDTH-1], {(WIDTH-1){~op_a[WIDTH-1]}}} : sum_raw;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      ptr_q     <= '0;
      rsp_id_q  <= '0;
      rsp_sum_q <= '0;
      rsp_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rsp_id_q  <= rsp_id_d;
      rsp_sum_q <= rsp_sum_d;
      rsp_sat_q <= rsp_sat_d;
    end
  end

  // Next-state logic
  always_comb begin
    free      = (state_q == EMPTY) || bus.rsp_ready;
    xfer      = found && free && rst_n;
    state_d   = state_q;
    ptr_d     = ptr_q;
    rsp_id_d  = rsp_id_q;
    rsp_sum_d = rsp_sum_q;
    rsp_sat_d = rsp_sat_q;
    if (xfer) begin
      state_d   = FULL;
      ptr_d     = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      rsp_id_d  = gnt_id;
      rsp_sum_d = sum_sat;
      rsp_sat_d = ovf;
    end else if (bus.rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // Outputs
  always_comb begin
    bus.req_ready = xfer ? (NREQ'(1) << gnt_id) : '0;
    bus.rsp_valid = (state_q == FULL);
    bus.rsp_id    = rsp_id_q;
    bus.rsp_sum   = rsp_sum_q;
    bus.rsp_sat   = rsp_sat_q;
  end

`ifdef SAT_ADD_ARB_STATS_EN
  logic [15:0] sat_count_q, sat_count_d;

  always_comb begin
    sat_count_d = sat_count_q;
    if (xfer && ovf && (sat_count_q != '1)) sat_count_d = sat_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_count_q <= '0;
    else        sat_count_q <= sat_count_d;
  end

  assign sat_count = sat_count_q;
`endif
endmodule

// File: tb/tb_sat_add_arbiter.sv
// Bench for sat_add_arbiter: vector table plus arbitration/backpressure/reset
// sequences, with a negedge scoreboard predicting grants and results.
module tb_sat_add_arbiter;
  localparam int WIDTH = 6;
  localparam int NREQ  = 4;
  localparam int NV    = 10;

  typedef struct {
    int id;
    int a;
    int b;
    int exp_sum;
    int exp_sat;
  } vec_t;

  typedef struct {
    int id;
    int sum;
    int sat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  sat_add_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

`ifdef SAT_ADD_ARB_STATS_EN
  logic [15:0] sat_count;
`endif

  sat_add_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SAT_ADD_ARB_STATS_EN
    ,
    .sat_count (sat_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void sat_model(input int a, input int b, output int s, output int f);
    s = a + b;
    f = 0;
    if (s > 31)  begin s = 31;  f = 1; end
    if (s < -32) begin s = -32; f = 1; end
  endfunction

  task automatic set_req(input int id, input int a, input int b);
    bus.req_a[id*WIDTH +: WIDTH] = WIDTH'(a);
    bus.req_b[id*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  // Scoreboard: predict grants at negedge, push on transfer, pop on consumption
  exp_t sb[$];
  int   mptr   = 0;
  bit   mvalid = 1'b0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      mptr   = 0;
      mvalid = 1'b0;
    end else begin
      exp_t e;
      bit   fnd;
      int   g, idx, s, f, expr;
      chk("rsp_valid_model", int'(bus.rsp_valid), int'(mvalid));
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got result id %0d expected none at %0t", bus.rsp_id, $time);
        end else begin
          e = sb.pop_front();
          chk("sb_id",  int'(bus.rsp_id), e.id);
          chk("sb_sum", int'($signed(bus.rsp_sum)), e.sum);
          chk("sb_sat", int'(bus.rsp_sat), e.sat);
        end
      end
      fnd = 1'b0;
      g   = 0;
      for (int k = 0; k < NREQ; k++) begin
        idx = (mptr + k) % NREQ;
        if (!fnd && bus.req_valid[idx]) begin
          fnd = 1'b1;
          g   = idx;
        end
      end
      expr = (fnd && (!mvalid || bus.rsp_ready)) ? (1 << g) : 0;
      chk("req_ready", int'(bus.req_ready), expr);
      if (expr != 0) begin
        sat_model(int'($signed(bus.req_a[g*WIDTH +: WIDTH])),
                  int'($signed(bus.req_b[g*WIDTH +: WIDTH])), s, f);
        e.id  = g;
        e.sum = s;
        e.sat = f;
        sb.push_back(e);
        mptr   = (g + 1) % NREQ;
        mvalid = 1'b1;
      end else if (bus.rsp_ready) begin
        mvalid = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tv[NV];
    bit   got;
    int   nsat;
    int   s, f;

    tv[0] = '{1,  10,  -3,   7, 0};
    tv[1] = '{0,  25,  10,  31, 1};
    tv[2] = '{3, -20, -20, -32, 1};
    tv[3] = '{2,  31,   1,  31, 1};
    tv[4] = '{1, -32,  -1, -32, 1};
    tv[5] = '{0, -32,  31,  -1, 0};
    tv[6] = '{3,  15,  16,  31, 0};
    tv[7] = '{2, -16, -16, -32, 0};
    tv[8] = '{0,   0,   0,   0, 0};
    tv[9] = '{1,  -1,   1,   0, 0};

    errors = 0;
    checks = 0;

    // Reset state with requests pending
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    #12;
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_id",    int'(bus.rsp_id), 0);
    chk("rst_rsp_sum",   int'(bus.rsp_sum), 0);
    chk("rst_rsp_sat",   int'(bus.rsp_sat), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    @(posedge clk); #1;
    rst_n         = 1'b1;
    bus.req_valid = '0;

    // Table vectors, one requester at a time
    nsat = 0;
    for (int v = 0; v < NV; v++) begin
      bus.req_valid = NREQ'(1 << tv[v].id);
      bus.req_a     = '0;
      bus.req_b     = '0;
      set_req(tv[v].id, tv[v].a, tv[v].b);
      bus.rsp_ready = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        got = bus.req_ready[tv[v].id];
      end
      chk("vec_grant_seen", int'(got), 1);
      @(posedge clk); #1;
      bus.req_valid = '0;
      chk("vec_valid", int'(bus.rsp_valid), 1);
      chk("vec_id",    int'(bus.rsp_id), tv[v].id);
      chk("vec_sum",   int'($signed(bus.rsp_sum)), tv[v].exp_sum);
      chk("vec_sat",   int'(bus.rsp_sat), tv[v].exp_sat);
      nsat += tv[v].exp_sat;
    end
`ifdef SAT_ADD_ARB_STATS_EN
    chk("sat_count", int'(sat_count), nsat);
`endif

    // Fresh reset so the round-robin pointer starts at 0
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    set_req(0,  25,  10);
    set_req(1, -20, -20);
    set_req(2,   7,  -9);
    set_req(3, -32,  31);
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("rr_id", int'(bus.rsp_id), k % NREQ);
    end

    // Backpressure: result holds, no grants
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("hold_valid", int'(bus.rsp_valid), 1);
      chk("hold_id",    int'(bus.rsp_id), 0);
      chk("hold_sum",   int'($signed(bus.rsp_sum)), 31);
      chk("hold_sat",   int'(bus.rsp_sat), 1);
      chk("hold_ready", int'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("release_grant", int'(bus.req_ready), 4'b0010);
    @(posedge clk); #1;
    chk("release_id",  int'(bus.rsp_id), 1);
    chk("release_sum", int'($signed(bus.rsp_sum)), -32);

    // Serve req 2 alone (ptr -> 3), then hold it and reset between edges
    bus.req_valid = 4'b0100;
    @(posedge clk); #1;
    chk("pre_rst_id", int'(bus.rsp_id), 2);
    bus.rsp_ready = 1'b0;
    bus.req_valid = 4'b1100;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(bus.rsp_valid), 0);
    chk("async_rst_id",    int'(bus.rsp_id), 0);
    chk("async_rst_sum",   int'(bus.rsp_sum), 0);
    chk("async_rst_ready", int'(bus.req_ready), 0);
    rst_n         = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    chk("post_rst_grant", int'(bus.req_ready), 4'b0100);
    @(posedge clk); #1;
    sat_model(7, -9, s, f);
    chk("post_rst_valid", int'(bus.rsp_valid), 1);
    chk("post_rst_id",    int'(bus.rsp_id), 2);
    chk("post_rst_sum",   int'($signed(bus.rsp_sum)), s);
    @(posedge clk); #1;
    chk("post_rst_id2",   int'(bus.rsp_id), 3);
    chk("post_rst_sum2",  int'($signed(bus.rsp_sum)), -1);
    chk("post_rst_sat2",  int'(bus.rsp_sat), 0);

    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
